pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Run-control and program-counter sequencer for the ACDC 9-bit processor. It owns the 10-bit PC that addresses the instruction ROM and the start/halt handshake, and inserts a one-cycle stall for data-memory loads. It also resolves branches through a writable 32-entry absolute-target lookup table and keeps the cycle and retired-instruction counters. It sits between the top level, the Ctrl decoder and the instruction ROM.

## Interface
- PW, 10, PC width (instruction ROM address)
- LUT_AW, 5, branch lookup-table index width (2^LUT_AW entries)
- CW, 16, counter width
- START_ADDR, 0, PC value on reset and on every start
- CLK  in  1  clock, posedge
- reset  in  1  asynchronous, active-high; one clock, no other clock domains
- start  in  1  synchronous run request (pulse or level)
- halt_req  in  1  decoded halt instruction at current PC
- mem_stall_req  in  1  current instruction is a load needing one extra cycle
- branch_en  in  1  taken branch at current PC (from Ctrl)
- branch_idx  in  LUT_AW  lookup-table entry holding branch target
- lut_we  in  1  lookup-table write enable
- lut_waddr  in  LUT_AW  lookup-table write index
- lut_wdata  in  PW  lookup-table write data (absolute target)
- PC  out  PW  instruction address
- halt  out  1  done flag
- running  out  1  state is RUN or WAIT
- stall  out  1  state is WAIT
- cycle_ct  out  CW  cycles spent in RUN/WAIT
- inst_ct  out  CW  instructions retired

## Operation
- States: IDLE, RUN, WAIT, HALT. Reset: IDLE, PC=START_ADDR, halt=0, running=0, stall=0, counters 0, all LUT entries 0.
- start=1 in any state has top priority: next state RUN, PC<=START_ADDR, both counters cleared, halt<=0.
- IDLE: holds until start.
- RUN, priority halt_req > mem_stall_req > branch_en > sequential:
  - halt_req: go to HALT. PC holds. inst_ct+1.
  - mem_stall_req: go to WAIT. PC holds. inst_ct unchanged.
  - branch_en: PC<=LUT[branch_idx]. inst_ct+1.
  - otherwise PC<=PC+1, wrapping 2^PW-1 -> 0. inst_ct+1.
- WAIT: lasts exactly one cycle. PC<=PC+1 (wrapping), inst_ct+1, return to RUN. halt_req, branch_en and mem_stall_req are ignored. A load is never a branch.
- HALT: halt=1, PC and counters frozen. Leaves only on start or reset.
- cycle_ct increments on every cycle spent in RUN or WAIT. Both counters saturate at 2^CW-1; they do not wrap.
- LUT write is accepted in every state. A branch reading the entry being written in the same cycle gets the old value.

## Timing
- All outputs registered. halt, running and stall decode directly from the state register.
- start sampled at edge N: PC=START_ADDR and running=1 after edge N; the first instruction executes in cycle N+1.
- Sequential or branch PC update: 1 cycle. A load occupies 2 cycles: RUN then WAIT.
- halt_req at edge N: halt=1 after edge N; PC still shows the halt instruction's address.
- reset asserted mid-run: immediate (asynchronous) return to the reset values, LUT included.
- start together with halt_req, branch_en or mem_stall_req: start wins.

## Structure
- Shared package acdc_pkg holds:
  - the state enum (IDLE/RUN/WAIT/HALT);
  - constants PW, LUT_AW, CW, START_ADDR, shared with the top level and instruction ROM.
- One sub-module, branch_lut: 2^LUT_AW x PW register array, synchronous write, asynchronous read, asynchronous clear on reset.
- FSM, PC register and counters live in pc_sequencer itself.

## Test plan
- Reset, pulse start, no requests for 5 cycles -> PC 0,1,2,3,4,5; running=1; cycle_ct=5; inst_ct=5.
- Write LUT[3]=0x155. At PC=2 assert branch_en with branch_idx=3 -> next PC=0x155. Same-cycle write LUT[3]=0x0AA with branch on idx 3 -> PC=0x155.
- mem_stall_req at PC=7 -> stall=1 for one cycle with PC=7, then PC=8; cycle_ct advances 2, inst_ct advances 1.
- halt_req at PC=9 -> halt=1, PC frozen at 9, counters frozen for 10 idle cycles. Then start -> PC=0, halt=0, counters 0.
- Force PC to 0x3FF via LUT branch, no requests -> PC=0x000. Preload counters near max -> each holds at 0xFFFF.
- Assert reset mid-WAIT -> state IDLE, PC=0, stall=0, all LUT entries read 0. start together with halt_req -> RUN at PC=0, halt=0.

Source files
------------

// File: rtl/acdc_pkg.sv
// Shared definitions for the ACDC 9-bit processor: machine widths, the
// program start address and the run-control state encoding.
package acdc_pkg;

    localparam int PW     = 10;
    localparam int LUT_AW = 5;
    localparam int CW     = 16;

    localparam logic [PW-1:0] START_ADDR = 10'd0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_WAIT = 2'd2,
        ST_HALT = 2'd3
    } seq_state_t;

endpackage

// File: rtl/branch_lut.sv
// Branch target lookup table: synchronous write, asynchronous read,
// whole array cleared asynchronously on reset.
module branch_lut #(
    parameter int AW = 5,
    parameter int DW = 10
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);

    localparam int DEPTH = 1 << AW;

    logic [DW-1:0] r_mem [DEPTH];

    // Table storage; a same-cycle read of the written entry sees the old value.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= {DW{1'b0}};
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/pc_sequencer.sv
// Run-control and program-counter sequencer: start/halt handshake, one-cycle
// load stall, LUT-resolved branches, saturating cycle and retire counters.
module pc_sequencer #(
    parameter int              PW         = acdc_pkg::PW,
    parameter int              LUT_AW     = acdc_pkg::LUT_AW,
    parameter int              CW         = acdc_pkg::CW,
    parameter logic [PW-1:0]   START_ADDR = acdc_pkg::START_ADDR
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              start,
    input  logic              halt_req,
    input  logic              mem_stall_req,
    input  logic              branch_en,
    input  logic [LUT_AW-1:0] branch_idx,
    input  logic              lut_we,
    input  logic [LUT_AW-1:0] lut_waddr,
    input  logic [PW-1:0]     lut_wdata,
    output logic [PW-1:0]     PC,
    output logic              halt,
    output logic              running,
    output logic              stall,
    output logic [CW-1:0]     cycle_ct,
    output logic [CW-1:0]     inst_ct
);

    import acdc_pkg::*;

    seq_state_t  r_state;
    logic [PW-1:0] r_pc;
    logic          r_halt;
    logic          r_running;
    logic          r_stall;
    logic [CW-1:0] r_cycle_ct;
    logic [CW-1:0] r_inst_ct;
    logic [PW-1:0] w_lut_rdata;
    logic [PW-1:0] w_pc_next_seq;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        sat_inc = (v == {CW{1'b1}}) ? v : v + {{(CW-1){1'b0}}, 1'b1};
    endfunction

    branch_lut #(
        .AW (LUT_AW),
        .DW (PW)
    ) u_branch_lut (
        .i_clk   (CLK),
        .i_rst   (reset),
        .i_we    (lut_we),
        .i_waddr (lut_waddr),
        .i_wdata (lut_wdata),
        .i_raddr (branch_idx),
        .o_rdata (w_lut_rdata)
    );

    assign w_pc_next_seq = r_pc + {{(PW-1){1'b0}}, 1'b1};

    // Run-control FSM, PC and counters; status flags track the next state.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_pc       <= START_ADDR;
            r_halt     <= 1'b0;
            r_running  <= 1'b0;
            r_stall    <= 1'b0;
            r_cycle_ct <= {CW{1'b0}};
            r_inst_ct  <= {CW{1'b0}};
        end else if (start) begin
            r_state    <= ST_RUN;
            r_pc       <= START_ADDR;
            r_halt     <= 1'b0;
            r_running  <= 1'b1;
            r_stall    <= 1'b0;
            r_cycle_ct <= {CW{1'b0}};
            r_inst_ct  <= {CW{1'b0}};
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_state <= ST_IDLE;
                end
                ST_RUN: begin
                    r_cycle_ct <= sat_inc(r_cycle_ct);
                    if (halt_req) begin
                        r_state   <= ST_HALT;
                        r_halt    <= 1'b1;
                        r_running <= 1'b0;
                        r_inst_ct <= sat_inc(r_inst_ct);
                    end else if (mem_stall_req) begin
                        r_state <= ST_WAIT;
                        r_stall <= 1'b1;
                    end else if (branch_en) begin
                        r_pc      <= w_lut_rdata;
                        r_inst_ct <= sat_inc(r_inst_ct);
                    end else begin
                        r_pc      <= w_pc_next_seq;
                        r_inst_ct <= sat_inc(r_inst_ct);
                    end
                end
                // The load completes here; a load is never a branch or halt.
                ST_WAIT: begin
                    r_state    <= ST_RUN;
                    r_stall    <= 1'b0;
                    r_pc       <= w_pc_next_seq;
                    r_cycle_ct <= sat_inc(r_cycle_ct);
                    r_inst_ct  <= sat_inc(r_inst_ct);
                end
                ST_HALT: begin
                    r_state <= ST_HALT;
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_halt    <= 1'b0;
                    r_running <= 1'b0;
                    r_stall   <= 1'b0;
                end
            endcase
        end
    end

    assign PC       = r_pc;
    assign halt     = r_halt;
    assign running  = r_running;
    assign stall    = r_stall;
    assign cycle_ct = r_cycle_ct;
    assign inst_ct  = r_inst_ct;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed vector table, hand-written
// corner sequences, and randomized stimulus against a behavioural model.
module tb_pc_sequencer;

    localparam int PW     = 10;
    localparam int LUT_AW = 5;
    localparam int CW     = 16;
    localparam int PC_MOD = 1 << PW;
    localparam int CT_MAX = (1 << CW) - 1;
    localparam int NLUT   = 1 << LUT_AW;

    logic              CLK = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic              halt_req = 1'b0;
    logic              mem_stall_req = 1'b0;
    logic              branch_en = 1'b0;
    logic [LUT_AW-1:0] branch_idx = '0;
    logic              lut_we = 1'b0;
    logic [LUT_AW-1:0] lut_waddr = '0;
    logic [PW-1:0]     lut_wdata = '0;
    logic [PW-1:0]     PC;
    logic              halt;
    logic              running;
    logic              stall;
    logic [CW-1:0]     cycle_ct;
    logic [CW-1:0]     inst_ct;

    always #5 CLK = ~CLK;

    pc_sequencer #(
        .PW(PW), .LUT_AW(LUT_AW), .CW(CW), .START_ADDR(10'd0)
    ) dut (
        .CLK(CLK), .reset(reset), .start(start), .halt_req(halt_req),
        .mem_stall_req(mem_stall_req), .branch_en(branch_en),
        .branch_idx(branch_idx), .lut_we(lut_we), .lut_waddr(lut_waddr),
        .lut_wdata(lut_wdata), .PC(PC), .halt(halt), .running(running),
        .stall(stall), .cycle_ct(cycle_ct), .inst_ct(inst_ct)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        int st, hr, ms, br, bidx, we, wa, wd;
        int pc, h, r, s, cyc, inst;
    } vec_t;
    vec_t vq[$];

    // Behavioural model: activity flags, plain-integer PC/counters, LUT array.
    bit m_active, m_loadpend, m_done;
    int m_pc, m_cyc, m_inst;
    int m_lut[NLUT];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input int pc, input int h, input int r,
                              input int s, input int c, input int i);
        check({tag, ".PC"}, 32'(PC), pc);
        check({tag, ".halt"}, 32'(halt), h);
        check({tag, ".running"}, 32'(running), r);
        check({tag, ".stall"}, 32'(stall), s);
        check({tag, ".cycle_ct"}, 32'(cycle_ct), c);
        check({tag, ".inst_ct"}, 32'(inst_ct), i);
    endtask

    task automatic set_in(input int st, input int hr, input int ms, input int br,
                          input int bidx, input int we, input int wa, input int wd);
        start = st[0];
        halt_req = hr[0];
        mem_stall_req = ms[0];
        branch_en = br[0];
        branch_idx = bidx[LUT_AW-1:0];
        lut_we = we[0];
        lut_waddr = wa[LUT_AW-1:0];
        lut_wdata = wd[PW-1:0];
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic add(input int st, input int hr, input int ms, input int br, input int bidx,
                       input int we, input int wa, input int wd, input int pc, input int h,
                       input int r, input int s, input int cyc, input int inst);
        vec_t v;
        v.st = st; v.hr = hr; v.ms = ms; v.br = br; v.bidx = bidx;
        v.we = we; v.wa = wa; v.wd = wd;
        v.pc = pc; v.h = h; v.r = r; v.s = s; v.cyc = cyc; v.inst = inst;
        vq.push_back(v);
    endtask

    function automatic int sat(input int v);
        return (v > CT_MAX) ? CT_MAX : v;
    endfunction

    task automatic model_reset();
        m_active = 1'b0; m_loadpend = 1'b0; m_done = 1'b0;
        m_pc = 0; m_cyc = 0; m_inst = 0;
        for (int i = 0; i < NLUT; i++) m_lut[i] = 0;
    endtask

    task automatic model_step(input int st, input int hr, input int ms, input int br,
                              input int bidx, input int we, input int wa, input int wd);
        int tgt;
        tgt = m_lut[bidx];
        if (st != 0) begin
            m_active = 1'b1; m_loadpend = 1'b0; m_done = 1'b0;
            m_pc = 0; m_cyc = 0; m_inst = 0;
        end else if (m_active) begin
            m_cyc = sat(m_cyc + 1);
            if (m_loadpend) begin
                m_loadpend = 1'b0;
                m_pc = (m_pc + 1) % PC_MOD;
                m_inst = sat(m_inst + 1);
            end else if (hr != 0) begin
                m_active = 1'b0;
                m_done = 1'b1;
                m_inst = sat(m_inst + 1);
            end else if (ms != 0) begin
                m_loadpend = 1'b1;
            end else begin
                m_pc = (br != 0) ? tgt : (m_pc + 1) % PC_MOD;
                m_inst = sat(m_inst + 1);
            end
        end
        if (we != 0) m_lut[wa] = wd;
    endtask

    task automatic check_model(input string tag);
        check_outs(tag, m_pc, int'(m_done), int'(m_active), int'(m_loadpend), m_cyc, m_inst);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int st, hr, ms, br, bidx, we, wa, wd;
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        #12;
        check_outs("reset", 0, 0, 0, 0, 0, 0);
        @(negedge CLK);
        reset = 1'b0;

        // st hr ms br idx we wa wd       | pc h r s cyc inst
        add(0, 0, 0, 1, 3, 1, 12, 'h2C0,     0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0, 0, 0,          0, 0, 1, 0, 0, 0);
        add(0, 0, 0, 0, 0, 1, 3, 'h155,      1, 0, 1, 0, 1, 1);
        for (int k = 2; k <= 5; k++) add(0, 0, 0, 0, 0, 0, 0, 0, k, 0, 1, 0, k, k);
        add(1, 0, 0, 0, 0, 0, 0, 0,          0, 0, 1, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0,          1, 0, 1, 0, 1, 1);
        add(0, 0, 0, 0, 0, 0, 0, 0,          2, 0, 1, 0, 2, 2);
        add(0, 0, 0, 1, 3, 0, 0, 0,          'h155, 0, 1, 0, 3, 3);
        add(0, 0, 0, 1, 3, 1, 3, 'h0AA,      'h155, 0, 1, 0, 4, 4);
        add(0, 0, 0, 1, 3, 0, 0, 0,          'h0AA, 0, 1, 0, 5, 5);
        add(1, 0, 0, 0, 0, 0, 0, 0,          0, 0, 1, 0, 0, 0);
        for (int k = 1; k <= 7; k++) add(0, 0, 0, 0, 0, 0, 0, 0, k, 0, 1, 0, k, k);
        add(0, 0, 1, 0, 0, 0, 0, 0,          7, 0, 1, 1, 8, 7);
        add(0, 1, 1, 1, 3, 0, 0, 0,          8, 0, 1, 0, 9, 8);
        add(0, 0, 0, 0, 0, 0, 0, 0,          9, 0, 1, 0, 10, 9);
        add(0, 1, 0, 0, 0, 0, 0, 0,          9, 1, 0, 0, 11, 10);
        add(0, 0, 1, 1, 3, 1, 9, 'h123,      9, 1, 0, 0, 11, 10);
        for (int k = 0; k < 9; k++) add(0, k % 2, 1, 1, 3, 0, 0, 0, 9, 1, 0, 0, 11, 10);
        add(1, 1, 0, 0, 0, 0, 0, 0,          0, 0, 1, 0, 0, 0);
        add(0, 0, 0, 0, 0, 1, 7, 'h3FF,      1, 0, 1, 0, 1, 1);
        add(0, 0, 0, 1, 7, 0, 0, 0,          'h3FF, 0, 1, 0, 2, 2);
        add(0, 0, 0, 0, 0, 0, 0, 0,          0, 0, 1, 0, 3, 3);
        add(0, 0, 0, 1, 5, 0, 0, 0,          0, 0, 1, 0, 4, 4);
        add(0, 0, 0, 1, 12, 0, 0, 0,         'h2C0, 0, 1, 0, 5, 5);
        add(0, 0, 0, 1, 9, 0, 0, 0,          'h123, 0, 1, 0, 6, 6);

        for (int n = 0; n < vq.size(); n++) begin
            set_in(vq[n].st, vq[n].hr, vq[n].ms, vq[n].br, vq[n].bidx,
                   vq[n].we, vq[n].wa, vq[n].wd);
            tick();
            check_outs($sformatf("vec%0d", n), vq[n].pc, vq[n].h, vq[n].r,
                       vq[n].s, vq[n].cyc, vq[n].inst);
        end

        // Reset while in WAIT, then read every LUT entry back via branches.
        set_in(0, 0, 1, 0, 0, 0, 0, 0);
        tick();
        check_outs("pre_reset_wait", 'h123, 0, 1, 1, 7, 6);
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        #2 reset = 1'b1;
        #1 check_outs("async_reset", 0, 0, 0, 0, 0, 0);
        #1 reset = 1'b0;
        tick();
        check_outs("idle_after_reset", 0, 0, 0, 0, 0, 0);
        set_in(1, 0, 0, 0, 0, 0, 0, 0);
        tick();
        check_outs("restart", 0, 0, 1, 0, 0, 0);
        for (int i = 0; i < NLUT; i++) begin
            set_in(0, 0, 0, 1, i, 0, 0, 0);
            tick();
            check($sformatf("lut_clear%0d.PC", i), 32'(PC), 0);
            check($sformatf("lut_clear%0d.inst_ct", i), 32'(inst_ct), i + 1);
        end

        // Counter saturation over a long free run.
        set_in(1, 0, 0, 0, 0, 0, 0, 0);
        tick();
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (65540) @(posedge CLK);
        #1;
        check_outs("sat_run", 65540 % PC_MOD, 0, 1, 0, CT_MAX, CT_MAX);
        set_in(0, 0, 1, 0, 0, 0, 0, 0);
        tick();
        check_outs("sat_load", 65540 % PC_MOD, 0, 1, 1, CT_MAX, CT_MAX);
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        check_outs("sat_wait", 65541 % PC_MOD, 0, 1, 0, CT_MAX, CT_MAX);

        // Randomized run against the behavioural model.
        #1 reset = 1'b1;
        model_reset();
        #1 check_model("rnd_init");
        #1 reset = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 399) == 0) begin
                #2 reset = 1'b1;
                model_reset();
                #1 check_model($sformatf("rnd_rst%0d", n));
                #1 reset = 1'b0;
            end
            st   = ($urandom_range(0, 39) == 0) ? 1 : 0;
            hr   = ($urandom_range(0, 24) == 0) ? 1 : 0;
            ms   = ($urandom_range(0, 7) == 0) ? 1 : 0;
            br   = ($urandom_range(0, 5) == 0) ? 1 : 0;
            bidx = $urandom_range(0, NLUT - 1);
            we   = ($urandom_range(0, 3) == 0) ? 1 : 0;
            wa   = ($urandom_range(0, 1) == 0) ? bidx : $urandom_range(0, NLUT - 1);
            wd   = ($urandom_range(0, 3) == 0) ? PC_MOD - 1 : $urandom_range(0, PC_MOD - 1);
            set_in(st, hr, ms, br, bidx, we, wa, wd);
            tick();
            model_step(st, hr, ms, br, bidx, we, wa, wd);
            check_model($sformatf("rnd%0d", n));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
